// File: rtl/rd_rsp_buffer.sv
// Credit-gated response buffer behind the fixed-latency read-data delay line.
// Holds returned words and presents them first-word-fall-through to the consumer.
module rd_rsp_buffer #(
  parameter int INPUT_BITS_NUM = 8,
  parameter int PTR_BITS       = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      rsp_valid,
  input  logic [INPUT_BITS_NUM-1:0] rsp_data,
  output logic [INPUT_BITS_NUM-1:0] data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic [PTR_BITS:0]         fifo_count,
  output logic [PTR_BITS:0]         outstanding,
  output logic                      err
);

  localparam int DEPTH = 2 ** PTR_BITS;
  localparam logic [PTR_BITS:0] FULL = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS+1:0] CAP = (PTR_BITS+2)'(DEPTH);

  logic [INPUT_BITS_NUM-1:0] mem [DEPTH];
  logic [PTR_BITS-1:0]       wr_ptr;
  logic [PTR_BITS-1:0]       rd_ptr;
  logic [PTR_BITS+1:0]       credits;
  logic                      issue;
  logic                      accept_rsp;
  logic                      pop;

  // Words held plus words in flight must never exceed the slots we own.
  assign credits    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_ready  = credits < CAP;
  assign issue      = req_valid && req_ready;
  assign accept_rsp = rsp_valid && (outstanding != '0) && (fifo_count != FULL);
  assign data_valid = fifo_count != '0;
  assign pop        = data_valid && data_ready;
  assign data_out   = data_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (accept_rsp) begin
      mem[wr_ptr] <= rsp_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (issue && !accept_rsp) begin
        outstanding <= outstanding + 1'b1;
      end else if (!issue && accept_rsp) begin
        outstanding <= outstanding - 1'b1;
      end
      if (accept_rsp && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!accept_rsp && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (accept_rsp) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Unexpected or unplaceable response: word is dropped, flag sticks.
      if (rsp_valid && !accept_rsp) begin
        err <= 1'b1;
      end
    end
  end

endmodule
